// File: rtl/bo_pkg.sv
//------------------------------------------------------------------------------
// bo_pkg : mux and ALU-op encodings shared by the bo datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bo_pkg;

  typedef enum logic [1:0] {
    SEL_RX = 2'b00,
    SEL_RS = 2'b01,
    SEL_RH = 2'b10,
    SEL_K  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_RX   = 2'b01,
    WB_ACC  = 2'b10,
    WB_ZERO = 2'b11
  } wb_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/bo_if.sv
//------------------------------------------------------------------------------
// bo_if : controller strobes, operand input and result handshake of bo
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bo_if #(
  parameter int WIDTH = 8
);
  logic             LX;
  logic             LS;
  logic             LH;
  logic             H;
  logic [1:0]       M0;
  logic [1:0]       M1;
  logic [1:0]       M2;
  logic             flag;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] result;
  logic             result_ovf;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;

  modport master (
    output LX, LS, LH, H, M0, M1, M2, flag, x_in, result_ready,
    input  result, result_ovf, result_valid, overrun
  );

  modport slave (
    input  LX, LS, LH, H, M0, M1, M2, flag, x_in, result_ready,
    output result, result_ovf, result_valid, overrun
  );
endinterface

`default_nettype wire

// File: rtl/bo_alu.sv
//------------------------------------------------------------------------------
// bo_alu : operand muxes, add/multiply, writeback mux and overflow detect.
// BO_SATURATE_EN: clamp overflowing writeback to all-ones. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bo_alu
  import bo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K0    = 2,
  parameter int K1    = 5
) (
  input  wire logic [WIDTH-1:0] rx_i,
  input  wire logic [WIDTH-1:0] rs_i,
  input  wire logic [WIDTH-1:0] rh_i,
  input  wire logic             h_i,
  input  wire logic [1:0]       m0_i,
  input  wire logic [1:0]       m1_i,
  input  wire logic [1:0]       m2_i,
  output logic      [WIDTH-1:0] wb_o,
  output logic                  ovf_o
);

  localparam logic [WIDTH-1:0] C_K0 = WIDTH'(K0);
  localparam logic [WIDTH-1:0] C_K1 = WIDTH'(K1);

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] w_mul;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_acc;
  logic [WIDTH-1:0]   w_alu;
  logic               w_alu_ovf;
  logic [WIDTH-1:0]   w_wb;

  always_comb begin
    w_a = rx_i;
    case (sel_e'(m0_i))
      SEL_RX: w_a = rx_i;
      SEL_RS: w_a = rs_i;
      SEL_RH: w_a = rh_i;
      SEL_K:  w_a = C_K0;
    endcase
    w_b = rx_i;
    case (sel_e'(m1_i))
      SEL_RX: w_b = rx_i;
      SEL_RS: w_b = rs_i;
      SEL_RH: w_b = rh_i;
      SEL_K:  w_b = C_K1;
    endcase
  end

  assign w_mul = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
  assign w_add = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    if (op_e'(h_i) == OP_MUL) begin
      w_alu     = w_mul[WIDTH-1:0];
      w_alu_ovf = |w_mul[2*WIDTH-1:WIDTH];
    end else begin
      w_alu     = w_add[WIDTH-1:0];
      w_alu_ovf = w_add[WIDTH];
    end
  end

  assign w_acc = {1'b0, w_alu} + {1'b0, rs_i};

  // Overflow only counts when the ALU result actually reaches the writeback.
  always_comb begin
    w_wb  = '0;
    ovf_o = 1'b0;
    case (wb_e'(m2_i))
      WB_ALU: begin
        w_wb  = w_alu;
        ovf_o = w_alu_ovf;
      end
      WB_RX: begin
        w_wb  = rx_i;
        ovf_o = 1'b0;
      end
      WB_ACC: begin
        w_wb  = w_acc[WIDTH-1:0];
        ovf_o = w_alu_ovf | w_acc[WIDTH];
      end
      WB_ZERO: begin
        w_wb  = '0;
        ovf_o = 1'b0;
      end
    endcase
  end

`ifdef BO_SATURATE_EN
  assign wb_o = ovf_o ? {WIDTH{1'b1}} : w_wb;
`else
  assign wb_o = w_wb;
`endif

endmodule

`default_nettype wire

// File: rtl/bo.sv
//------------------------------------------------------------------------------
// bo : datapath with RX/RS/RH, sticky overflow and result capture handshake.
// BO_SATURATE_EN (in bo_alu): saturating writeback. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bo
  import bo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K0    = 2,
  parameter int K1    = 5
) (
  input wire logic clock,
  input wire logic reset,
  bo_if.slave      bus
);

  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rh_q, rh_d;
  logic             ovf_q, ovf_d;
  logic             flag_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_ovf_q, result_ovf_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] w_wb;
  logic             w_wb_ovf;
  logic             w_capture;

  bo_alu #(
    .WIDTH (WIDTH),
    .K0    (K0),
    .K1    (K1)
  ) u_alu (
    .rx_i  (rx_q),
    .rs_i  (rs_q),
    .rh_i  (rh_q),
    .h_i   (bus.H),
    .m0_i  (bus.M0),
    .m1_i  (bus.M1),
    .m2_i  (bus.M2),
    .wb_o  (w_wb),
    .ovf_o (w_wb_ovf)
  );

  always_comb begin
    rx_d  = bus.LX ? bus.x_in : rx_q;
    rs_d  = bus.LS ? w_wb : rs_q;
    rh_d  = bus.LH ? w_wb : rh_q;
    ovf_d = ovf_q;
    if ((bus.LS || bus.LH) && w_wb_ovf) ovf_d = 1'b1;
    if (bus.LX) ovf_d = 1'b0;
  end

  assign w_capture = bus.flag && !flag_q;

  // A capture coinciding with a transfer reloads the buffer without a bubble.
  always_comb begin
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    if (w_capture) begin
      if (!valid_q || bus.result_ready) begin
        result_d     = rs_q;
        result_ovf_d = ovf_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.result_ready) begin
      valid_d = 1'b0;
    end
  end

  // flag_q resets high so the controller's idle-high flag is not a capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_q         <= '0;
      rs_q         <= '0;
      rh_q         <= '0;
      ovf_q        <= 1'b0;
      flag_q       <= 1'b1;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_q         <= rx_d;
      rs_q         <= rs_d;
      rh_q         <= rh_d;
      ovf_q        <= ovf_d;
      flag_q       <= bus.flag;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_ovf   = result_ovf_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = overrun_q;

endmodule

`default_nettype wire
